// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: operand-forward select
// encodings, controller FSM state encodings and the register-match helper.
package hazard_ctrl_pkg;

    // Execute-stage operand source select
    localparam logic [1:0] NO_FWD      = 2'd0;
    localparam logic [1:0] FWD_MEM     = 2'd1;
    localparam logic [1:0] FWD_WB      = 2'd2;
    localparam logic [1:0] FWD_REG_RDW = 2'd3;

    // Hazard controller FSM states
    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] LOAD_STALL = 2'd1;
    localparam logic [1:0] MEM_WAIT   = 2'd2;

    // x0 is hard-wired to zero, so it never produces a dependency
    function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Per-operand forward select: MEM result beats WB result beats the value
// saved across a stall; otherwise the register file value is used.
module fwd_select
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] srcAddr,
    input  logic       memRegWr,
    input  logic [4:0] memRdAddr,
    input  logic       wbRegWr,
    input  logic [4:0] wbRdAddr,
    input  logic       savedFlag,
    output logic [1:0] fwdSel
);

    // Priority decode of the youngest producer of this source register
    always_comb begin
        // NOTE: default assignment first so every path drives fwdSel and no latch is inferred.
        fwdSel = NO_FWD;
        if (memRegWr && regMatch(srcAddr, memRdAddr)) begin
            fwdSel = FWD_MEM;
        end else if (wbRegWr && regMatch(srcAddr, wbRdAddr)) begin
            fwdSel = FWD_WB;
        end else if (savedFlag) begin
            fwdSel = FWD_REG_RDW;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use bubble insertion,
// data-memory wait stalls, taken-branch flushes and capture of write-back data
// that would otherwise be lost while EX is held.
// Optional build macro HAZARD_STALL_CNT_EN adds a saturating o_stallCount.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [4:0]      i_ID_rs1Addr,
    input  logic [4:0]      i_ID_rs2Addr,
    input  logic [4:0]      i_EXEC_rs1Addr,
    input  logic [4:0]      i_EXEC_rs2Addr,
    input  logic [4:0]      i_EXEC_rdAddr,
    input  logic            i_EXEC_memRd,
    input  logic [4:0]      i_MEM_rdAddr,
    input  logic            i_MEM_regWr,
    input  logic [4:0]      i_WB_rdAddr,
    input  logic            i_WB_regWr,
    input  logic [XLEN-1:0] i_WB_rdData,
    input  logic            i_memBusy,
    input  logic            i_branchTaken,
    output logic [1:0]      o_fwdRs1,
    output logic [1:0]      o_fwdRs2,
    output logic [XLEN-1:0] o_rdDataSave,
    output logic            o_stallIF,
    output logic            o_stallID,
    output logic            o_stallEX,
    output logic            o_stallMEM,
    output logic            o_flushID,
    output logic            o_flushEX,
    output logic            o_flushWB
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]     o_stallCount
`endif
);

    logic [1:0] state;
    logic [1:0] stateNext;
    logic       memStall;
    logic       loadUse;
    logic       branchFlush;
    logic       savedRs1;
    logic       savedRs2;
    logic       prevStallEX;
    logic [1:0] fwdRs1Raw;
    logic [1:0] fwdRs2Raw;

    fwd_select u_fwdRs1 (
        .srcAddr   (i_EXEC_rs1Addr),
        .memRegWr  (i_MEM_regWr),
        .memRdAddr (i_MEM_rdAddr),
        .wbRegWr   (i_WB_regWr),
        .wbRdAddr  (i_WB_rdAddr),
        .savedFlag (savedRs1),
        .fwdSel    (fwdRs1Raw)
    );

    fwd_select u_fwdRs2 (
        .srcAddr   (i_EXEC_rs2Addr),
        .memRegWr  (i_MEM_regWr),
        .memRdAddr (i_MEM_rdAddr),
        .wbRegWr   (i_WB_regWr),
        .wbRdAddr  (i_WB_rdAddr),
        .savedFlag (savedRs2),
        .fwdSel    (fwdRs2Raw)
    );

    // Hazard detection and next-state selection; memory wait outranks load-use,
    // and a taken branch squashes the dependent instruction instead of stalling
    always_comb begin
        memStall    = i_memBusy || (state == MEM_WAIT);
        loadUse     = (state == RUN) && !memStall && !i_branchTaken && i_EXEC_memRd &&
                      (regMatch(i_EXEC_rdAddr, i_ID_rs1Addr) ||
                       regMatch(i_EXEC_rdAddr, i_ID_rs2Addr));
        branchFlush = i_branchTaken && !memStall;

        stateNext = state;
        case (state)
            RUN: begin
                if (i_memBusy) begin
                    stateNext = MEM_WAIT;
                end else if (loadUse) begin
                    stateNext = LOAD_STALL;
                end
            end
            LOAD_STALL: stateNext = i_memBusy ? MEM_WAIT : RUN;
            MEM_WAIT:   stateNext = i_memBusy ? MEM_WAIT : RUN;
            default:    stateNext = RUN;
        endcase
    end

    // Output decode, forced quiet while reset is held
    always_comb begin
        o_stallIF  = !i_rst && (memStall || loadUse);
        o_stallID  = !i_rst && (memStall || loadUse);
        o_stallEX  = !i_rst && memStall;
        o_stallMEM = !i_rst && memStall;
        o_flushID  = !i_rst && branchFlush;
        o_flushEX  = !i_rst && (branchFlush || loadUse);
        o_flushWB  = !i_rst && memStall;
        o_fwdRs1   = i_rst ? NO_FWD : fwdRs1Raw;
        o_fwdRs2   = i_rst ? NO_FWD : fwdRs2Raw;
    end

    // Controller state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= RUN;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= stateNext;
        end
    end

    // Keep the write-back value EX depends on when the stall flushes WB;
    // flags drop as soon as EX moves on
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prevStallEX  <= 1'b0;
            savedRs1     <= 1'b0;
            savedRs2     <= 1'b0;
            o_rdDataSave <= '0;
        end else begin
            prevStallEX <= memStall;
            if (memStall && !prevStallEX) begin
                if (i_WB_regWr && regMatch(i_WB_rdAddr, i_EXEC_rs1Addr)) begin
                    o_rdDataSave <= i_WB_rdData;
                    savedRs1     <= 1'b1;
                end
                if (i_WB_regWr && regMatch(i_WB_rdAddr, i_EXEC_rs2Addr)) begin
                    o_rdDataSave <= i_WB_rdData;
                    savedRs2     <= 1'b1;
                end
            end else if (!memStall) begin
                savedRs1 <= 1'b0;
                savedRs2 <= 1'b0;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    // Saturating count of cycles in which fetch was held
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stallCount <= '0;
        end else if (o_stallIF && (o_stallCount != 32'hFFFF_FFFF)) begin
            o_stallCount <= o_stallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
// Honours HAZARD_STALL_CNT_EN when the design is built with it.
module tb_hazard_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic [4:0]  i_ID_rs1Addr, i_ID_rs2Addr;
    logic [4:0]  i_EXEC_rs1Addr, i_EXEC_rs2Addr, i_EXEC_rdAddr;
    logic        i_EXEC_memRd;
    logic [4:0]  i_MEM_rdAddr;
    logic        i_MEM_regWr;
    logic [4:0]  i_WB_rdAddr;
    logic        i_WB_regWr;
    logic [31:0] i_WB_rdData;
    logic        i_memBusy, i_branchTaken;
    logic [1:0]  o_fwdRs1, o_fwdRs2;
    logic [31:0] o_rdDataSave;
    logic        o_stallIF, o_stallID, o_stallEX, o_stallMEM;
    logic        o_flushID, o_flushEX, o_flushWB;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] o_stallCount;
`endif

    int nCompared = 0;
    int nMismatch = 0;

    // Model: memory wait lasts while busy plus one cycle; a load-use bubble
    // cannot immediately follow another; saved data captured on stall entry
    bit          mPrevBusy, mPrevLu, mPrevMemStall, mFlag1, mFlag2;
    logic [31:0] mSave;
    longint      mCount;

    hazard_ctrl #(.XLEN(32)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_ID_rs1Addr   (i_ID_rs1Addr),
        .i_ID_rs2Addr   (i_ID_rs2Addr),
        .i_EXEC_rs1Addr (i_EXEC_rs1Addr),
        .i_EXEC_rs2Addr (i_EXEC_rs2Addr),
        .i_EXEC_rdAddr  (i_EXEC_rdAddr),
        .i_EXEC_memRd   (i_EXEC_memRd),
        .i_MEM_rdAddr   (i_MEM_rdAddr),
        .i_MEM_regWr    (i_MEM_regWr),
        .i_WB_rdAddr    (i_WB_rdAddr),
        .i_WB_regWr     (i_WB_regWr),
        .i_WB_rdData    (i_WB_rdData),
        .i_memBusy      (i_memBusy),
        .i_branchTaken  (i_branchTaken),
        .o_fwdRs1       (o_fwdRs1),
        .o_fwdRs2       (o_fwdRs2),
        .o_rdDataSave   (o_rdDataSave),
        .o_stallIF      (o_stallIF),
        .o_stallID      (o_stallID),
        .o_stallEX      (o_stallEX),
        .o_stallMEM     (o_stallMEM),
        .o_flushID      (o_flushID),
        .o_flushEX      (o_flushEX),
        .o_flushWB      (o_flushWB)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .o_stallCount   (o_stallCount)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwdRef(input logic [4:0] src, input bit flag);
        if (src == 5'd0) return flag ? 32'd3 : 32'd0;
        if (i_MEM_regWr && i_MEM_rdAddr == src) return 32'd1;
        if (i_WB_regWr && i_WB_rdAddr == src) return 32'd2;
        return flag ? 32'd3 : 32'd0;
    endfunction

    task automatic clearIns();
        i_ID_rs1Addr = 0; i_ID_rs2Addr = 0;
        i_EXEC_rs1Addr = 0; i_EXEC_rs2Addr = 0; i_EXEC_rdAddr = 0; i_EXEC_memRd = 0;
        i_MEM_rdAddr = 0; i_MEM_regWr = 0;
        i_WB_rdAddr = 0; i_WB_regWr = 0; i_WB_rdData = 0;
        i_memBusy = 0; i_branchTaken = 0;
    endtask

    task automatic modelReset();
        mPrevBusy = 0; mPrevLu = 0; mPrevMemStall = 0;
        mFlag1 = 0; mFlag2 = 0; mSave = 0; mCount = 0;
    endtask

    function automatic bit modelMemStall();
        return i_memBusy || mPrevBusy;
    endfunction

    function automatic bit modelLoadUse();
        bit hazard;
        hazard = i_EXEC_memRd && (i_EXEC_rdAddr != 0) &&
                 ((i_EXEC_rdAddr == i_ID_rs1Addr) || (i_EXEC_rdAddr == i_ID_rs2Addr));
        return !modelMemStall() && !mPrevLu && !i_branchTaken && hazard;
    endfunction

    // Compare every output against the model for the current cycle
    task automatic checkModel();
        bit ms, lu, br;
        ms = modelMemStall();
        lu = modelLoadUse();
        br = i_branchTaken && !ms;
        chk("stallIF",  o_stallIF,  ms || lu);
        chk("stallID",  o_stallID,  ms || lu);
        chk("stallEX",  o_stallEX,  ms);
        chk("stallMEM", o_stallMEM, ms);
        chk("flushID",  o_flushID,  br);
        chk("flushEX",  o_flushEX,  br || lu);
        chk("flushWB",  o_flushWB,  ms);
        chk("fwdRs1",   o_fwdRs1,   fwdRef(i_EXEC_rs1Addr, mFlag1));
        chk("fwdRs2",   o_fwdRs2,   fwdRef(i_EXEC_rs2Addr, mFlag2));
        chk("rdDataSave", o_rdDataSave, mSave);
`ifdef HAZARD_STALL_CNT_EN
        chk("stallCount", o_stallCount, mCount[31:0]);
`endif
    endtask

    // Cross the clock edge and update the model from the inputs just applied
    task automatic advance();
        bit ms, lu;
        ms = modelMemStall();
        lu = modelLoadUse();
        @(posedge i_clk);
        #1;
        if (ms && !mPrevMemStall && i_WB_regWr && i_WB_rdAddr != 0) begin
            if (i_WB_rdAddr == i_EXEC_rs1Addr) begin mSave = i_WB_rdData; mFlag1 = 1; end
            if (i_WB_rdAddr == i_EXEC_rs2Addr) begin mSave = i_WB_rdData; mFlag2 = 1; end
        end
        if (!ms) begin mFlag1 = 0; mFlag2 = 0; end
        if ((ms || lu) && mCount < 64'hFFFF_FFFF) mCount++;
        mPrevBusy = i_memBusy;
        mPrevLu = lu;
        mPrevMemStall = ms;
    endtask

    task automatic step();
        #3;
        checkModel();
        advance();
    endtask

    initial begin
        // Reset held with hazards present: everything must stay quiet
        clearIns();
        modelReset();
        i_rst = 1'b1;
        i_memBusy = 1; i_branchTaken = 1;
        i_MEM_regWr = 1; i_MEM_rdAddr = 5; i_EXEC_rs1Addr = 5;
        @(posedge i_clk); #4;
        chk("rst_stallIF",  o_stallIF,  0);
        chk("rst_stallEX",  o_stallEX,  0);
        chk("rst_flushID",  o_flushID,  0);
        chk("rst_flushWB",  o_flushWB,  0);
        chk("rst_fwdRs1",   o_fwdRs1,   0);
        chk("rst_rdDataSave", o_rdDataSave, 0);
        clearIns();
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // MEM beats WB on the same register; x0 never forwards
        i_MEM_regWr = 1; i_MEM_rdAddr = 5; i_WB_regWr = 1; i_WB_rdAddr = 5; i_EXEC_rs1Addr = 5;
        #3; chk("fwd_mem_over_wb", o_fwdRs1, 1); checkModel(); advance();
        i_MEM_rdAddr = 0; i_EXEC_rs1Addr = 0;
        #3; chk("fwd_x0", o_fwdRs1, 0); checkModel(); advance();

        // Load-use: one bubble, then clear
        clearIns();
        i_EXEC_memRd = 1; i_EXEC_rdAddr = 7; i_ID_rs2Addr = 7;
        #3; chk("lu_stallIF", o_stallIF, 1); chk("lu_flushEX", o_flushEX, 1); chk("lu_stallEX", o_stallEX, 0);
        checkModel(); advance();
        #3; chk("lu_after_stallIF", o_stallIF, 0); chk("lu_after_flushEX", o_flushEX, 0);
        checkModel(); advance();
        clearIns();
        step();

        // Memory wait with write-back capture
        i_memBusy = 1; i_WB_regWr = 1; i_WB_rdAddr = 3; i_WB_rdData = 32'hDEAD_BEEF; i_EXEC_rs1Addr = 3;
        repeat (3) step();
        i_memBusy = 0; i_WB_regWr = 0;
        #3; chk("save_data", o_rdDataSave, 32'hDEAD_BEEF); chk("save_fwd_wait", o_fwdRs1, 3);
        chk("save_stallEX", o_stallEX, 1); checkModel(); advance();
        #3; chk("save_fwd_adv", o_fwdRs1, 3); chk("save_run_stallEX", o_stallEX, 0);
        checkModel(); advance();
        #3; chk("save_fwd_clr", o_fwdRs1, 0); checkModel(); advance();

        // Taken branch overrides load-use; controller must still be in RUN
        clearIns();
        i_EXEC_memRd = 1; i_EXEC_rdAddr = 7; i_ID_rs1Addr = 7; i_branchTaken = 1;
        #3; chk("br_flushID", o_flushID, 1); chk("br_flushEX", o_flushEX, 1); chk("br_stallIF", o_stallIF, 0);
        checkModel(); advance();
        i_branchTaken = 0;
        #3; chk("br_still_run", o_stallIF, 1); checkModel(); advance();
        clearIns();
        step();

        // Reset in the middle of a memory wait
        i_memBusy = 1;
        step(); step();
        i_rst = 1'b1;
        #1;
        chk("midrst_stallIF", o_stallIF, 0); chk("midrst_stallMEM", o_stallMEM, 0);
        chk("midrst_flushWB", o_flushWB, 0); chk("midrst_save", o_rdDataSave, 0);
`ifdef HAZARD_STALL_CNT_EN
        chk("midrst_count", o_stallCount, 0);
`endif
        #2;
        clearIns();
        i_rst = 1'b0;
        modelReset();
        @(posedge i_clk); #1;
        #3; chk("postrst_run", o_stallIF, 0); checkModel(); advance();

        // Three busy cycles plus the wait-exit cycle make four stall cycles
        i_memBusy = 1;
        repeat (3) step();
        i_memBusy = 0;
        step();
`ifdef HAZARD_STALL_CNT_EN
        #3; chk("count_four", o_stallCount, 4); checkModel(); advance();
`else
        step();
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            i_ID_rs1Addr   = 5'($urandom_range(0, 3));
            i_ID_rs2Addr   = 5'($urandom_range(0, 3));
            i_EXEC_rs1Addr = 5'($urandom_range(0, 3));
            i_EXEC_rs2Addr = 5'($urandom_range(0, 3));
            i_EXEC_rdAddr  = 5'($urandom_range(0, 3));
            i_EXEC_memRd   = 1'($urandom_range(0, 1));
            i_MEM_rdAddr   = 5'($urandom_range(0, 3));
            i_MEM_regWr    = 1'($urandom_range(0, 1));
            i_WB_rdAddr    = 5'($urandom_range(0, 3));
            i_WB_regWr     = 1'($urandom_range(0, 1));
            i_WB_rdData    = $urandom;
            i_memBusy      = ($urandom_range(0, 3) == 0);
            i_branchTaken  = ($urandom_range(0, 6) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
